pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- REGW, 4, register-index width
- CNTW, 16, performance-counter width
- MEM_TIMEOUT, 15, maximum DMEM wait cycles before a timeout is flagged
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- id_rs / id_rt, in, REGW, decode-stage source registers
- id_rs_used / id_rt_used, in, 1, the corresponding source is read
- ex_rd, in, REGW, execute-stage destination register
- ex_mem_read, in, 1, execute stage holds a load
- id_br_mispredict, in, 1, branch resolved in decode disagrees with the fetched path
- imem_ready, in, 1, instruction memory has valid data this cycle
- mem_req / dmem_ready, in, 1, memory stage access pending / complete
- wb_halt, in, 1, HLT instruction is in writeback
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, out, 1, pipeline-register write enables
- if_id_flush / id_ex_bubble / wb_kill, out, 1, insert a NOP into IF/ID, ID/EX, or suppress the writeback write
- halted, out, 1, core stopped
- mem_timeout, out, 1, sticky DMEM timeout flag
- stall_cnt / flush_cnt, out, CNTW, performance counters
- state, out, 3, FSM state (debug)

Function
REQ-003 Hazard conditions are evaluated each cycle, in priority order:
- HALT
- DMEM (mem_req && !dmem_ready)
- LU (ex_mem_read && ex_rd!=0 && ((id_rs_used && id_rs==ex_rd) || (id_rt_used && id_rt==ex_rd)))
- BR (id_br_mispredict)
- IMEM (!imem_ready)
- none
REQ-004 Outputs are combinational from the current state and inputs. All enables default to 1 and all flush/kill signals default to 0.
REQ-005 DMEM condition: all five enables SHALL be 0 and wb_kill SHALL be 1.
REQ-006 LU condition: pc_en=0, if_id_en=0 and id_ex_bubble=1; the remaining stages advance.
REQ-007 BR condition: if_id_flush=1 and pc_en=1 (redirect is taken). A BR masked by DMEM or LU SHALL NOT flush; it is re-evaluated the next cycle.
REQ-008 IMEM condition: pc_en=0 and if_id_flush=1; the remaining stages advance.
REQ-009 FSM states: RUN=0, LU_STALL=1, DMEM_WAIT=2, IMEM_WAIT=3, HALTED=4.
- Next state is the winning condition of the cycle (none->RUN, BR->RUN).
- HALTED is absorbing until rst.
REQ-010 In HALTED: all enables=0, wb_kill=1, halted=1. Inputs are ignored and the counters freeze.
REQ-011 wb_halt SHALL enter HALTED on the next edge. In that cycle, writeback of the HLT itself still completes (wb_kill=0 unless DMEM is active).
REQ-012 A DMEM wait counter SHALL:
- increment each cycle in DMEM_WAIT while the DMEM condition holds;
- clear on leaving DMEM_WAIT;
- set mem_timeout when it exceeds MEM_TIMEOUT.
mem_timeout SHALL stay set until rst and has no effect on stalling.
REQ-013 stall_cnt SHALL increment by 1 on every non-HALTED cycle with DMEM, LU or IMEM active, saturating at all-ones.
REQ-014 flush_cnt SHALL increment by 1 on every cycle where if_id_flush is caused by BR, saturating at all-ones.
REQ-015 LU SHALL produce exactly one stall cycle per load-use pair, because the ID/EX bubble removes the load from EX.
REQ-016 Register 0 is never a hazard source.

Reset
REQ-017 When rst=1 at a clock edge, the block SHALL set state=RUN, stall_cnt=0, flush_cnt=0, wait counter=0, mem_timeout=0 and halted=0, regardless of current state, including HALTED and DMEM_WAIT.
REQ-018 While rst is asserted, outputs SHALL reflect RUN with no hazard: all enables=1, all flush/kill signals=0.

Verification
REQ-019 Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_rs_used=1 for one cycle. Required response:
- that cycle: pc_en=0, if_id_en=0, id_ex_bubble=1;
- next cycle: state=LU_STALL;
- stall_cnt=1.
Repeating with ex_rd=0 SHALL produce no stall.
REQ-020 Mispredict: id_br_mispredict=1 alone for one cycle. Required response: if_id_flush=1, pc_en=1, flush_cnt=1. Repeating with a simultaneous load-use SHALL give a stall only (flush_cnt unchanged); the flush SHALL occur the following cycle.
REQ-021 DMEM wait: mem_req=1, dmem_ready=0 for 3 cycles, then dmem_ready=1. Required response:
- all enables=0 and wb_kill=1 for 3 cycles;
- state=DMEM_WAIT;
- stall_cnt=3;
- mem_timeout=0.
REQ-022 Timeout: hold dmem_ready=0 for 20 cycles. Required response: mem_timeout becomes 1 after cycle 16 and stays 1 after the wait ends; it clears only on rst.
REQ-023 Halt: wb_halt=1 for one cycle, then random inputs. Required response:
- halted=1 and all enables=0 from the next cycle;
- counters frozen;
- rst restores state=RUN and zeroes all counters.
REQ-024 IMEM miss: imem_ready=0 for 2 cycles. Required response: pc_en=0 and if_id_flush=1 for those 2 cycles, with id_ex_en=ex_mem_en=mem_wb_en=1; stall_cnt=2.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: picks the winning hazard each cycle and drives
// stage enables, bubble/flush/kill controls and stall/flush perf counters.
// Control outputs are combinational from state and inputs; state and counters update on the next clk edge.
module pipeline_hazard_ctrl #(
  parameter int REGW        = 4,
  parameter int CNTW        = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_mem_read,
  input  logic            id_br_mispredict,
  input  logic            imem_ready,
  input  logic            mem_req,
  input  logic            dmem_ready,
  input  logic            wb_halt,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_ex_bubble,
  output logic            wb_kill,
  output logic            halted,
  output logic            mem_timeout,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    LU_STALL  = 3'd1,
    DMEM_WAIT = 3'd2,
    IMEM_WAIT = 3'd3,
    HALTED    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_HALT, C_DMEM, C_LU, C_BR, C_IMEM
  } cond_t;

  // Wait counter saturates one past the limit so "exceeded" stays representable.
  localparam int WW = $clog2(MEM_TIMEOUT + 2);

  state_t          state_q, state_d;
  cond_t           win;
  logic            dmem_c, lu_c;
  logic [WW-1:0]   wait_cnt_q;
  logic [WW-1:0]   wait_nxt;

  // Raw hazard conditions; register 0 never creates a load-use dependency.
  always_comb begin
    dmem_c = mem_req && !dmem_ready;
    lu_c   = ex_mem_read && (ex_rd != '0) &&
             ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));
  end

  // Priority resolution; nothing wins while in reset or once halted.
  always_comb begin
    win = C_NONE;
    if (rst || state_q == HALTED)   win = C_NONE;
    else if (wb_halt)               win = C_HALT;
    else if (dmem_c)                win = C_DMEM;
    else if (lu_c)                  win = C_LU;
    else if (id_br_mispredict)      win = C_BR;
    else if (!imem_ready)           win = C_IMEM;
  end

  // Next-state and pipeline control outputs from the winning condition.
  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    wb_kill      = 1'b0;
    halted       = 1'b0;
    if (!rst && state_q == HALTED) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      wb_kill   = 1'b1;
      halted    = 1'b1;
    end else begin
      case (win)
        C_HALT: begin
          // The HLT itself still retires unless the memory stage is blocked.
          state_d = HALTED;
          if (dmem_c) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            wb_kill   = 1'b1;
          end
        end
        C_DMEM: begin
          state_d   = DMEM_WAIT;
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
          wb_kill   = 1'b1;
        end
        C_LU: begin
          state_d      = LU_STALL;
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end
        C_BR: begin
          state_d     = RUN;
          if_id_flush = 1'b1;
        end
        C_IMEM: begin
          state_d     = IMEM_WAIT;
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State register; HALTED holds because state_d defaults to state_q.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign state = rst ? 3'(RUN) : 3'(state_q);

  // Next DMEM wait count, saturating just past the timeout limit.
  always_comb begin
    wait_nxt = wait_cnt_q;
    if (wait_cnt_q != WW'(MEM_TIMEOUT + 1)) wait_nxt = wait_cnt_q + 1'b1;
  end

  // DMEM wait tracking and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else if (win == C_DMEM) begin
      wait_cnt_q <= wait_nxt;
      if (wait_nxt > WW'(MEM_TIMEOUT)) mem_timeout <= 1'b1;
    end else if (state_q != HALTED) begin
      wait_cnt_q <= '0;
    end
  end

  // Saturating performance counters; frozen while halted since win is C_NONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((win == C_DMEM || win == C_LU || win == C_IMEM || (win == C_HALT && dmem_c)) &&
          stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (win == C_BR && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_rs, id_rt, ex_rd;
  logic        id_rs_used, id_rt_used, ex_mem_read, id_br_mispredict;
  logic        imem_ready, mem_req, dmem_ready, wb_halt;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_bubble, wb_kill, halted, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REGW(4), .CNTW(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .id_br_mispredict(id_br_mispredict),
    .imem_ready(imem_ready), .mem_req(mem_req), .dmem_ready(dmem_ready), .wb_halt(wb_halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .wb_kill(wb_kill), .halted(halted), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  wire [4:0] ens = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 4'd0; id_rt = 4'd0; ex_rd = 4'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; ex_mem_read = 1'b0;
    id_br_mispredict = 1'b0; imem_ready = 1'b1; mem_req = 1'b0;
    dmem_ready = 1'b1; wb_halt = 1'b0;
  endtask

  initial begin
    // Reset with a DMEM hazard present: outputs must still look like idle RUN.
    idle();
    rst = 1'b1;
    mem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("rst_ens", 32'(ens), 32'h1f);
    chk("rst_kill", 32'(wb_kill), 32'h0);
    tick(); tick();
    idle();
    rst = 1'b0;
    #1;
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_stall", 32'(stall_cnt), 32'd0);
    chk("post_rst_flush", 32'(flush_cnt), 32'd0);
    chk("post_rst_tmo", 32'(mem_timeout), 32'd0);
    chk("post_rst_halted", 32'(halted), 32'd0);
    chk("post_rst_ens", 32'(ens), 32'h1f);

    // Load-use on rs.
    ex_mem_read = 1'b1; ex_rd = 4'd5; id_rs = 4'd5; id_rs_used = 1'b1;
    #1;
    chk("lu_ens", 32'(ens), 32'b00111);
    chk("lu_bubble", 32'(id_ex_bubble), 32'h1);
    tick();
    chk("lu_state", 32'(state), 32'd1);
    chk("lu_stall", 32'(stall_cnt), 32'd1);
    ex_mem_read = 1'b0;
    #1;
    chk("lu_release_pc", 32'(pc_en), 32'h1);
    tick();
    chk("lu_back_run", 32'(state), 32'd0);

    // Load into r0 is never a hazard.
    ex_mem_read = 1'b1; ex_rd = 4'd0; id_rs = 4'd0; id_rs_used = 1'b1;
    #1;
    chk("r0_pc", 32'(pc_en), 32'h1);
    chk("r0_bubble", 32'(id_ex_bubble), 32'h0);
    tick();
    chk("r0_stall", 32'(stall_cnt), 32'd1);

    // Load-use through rt, then a matching rt that is not read.
    idle();
    ex_mem_read = 1'b1; ex_rd = 4'd7; id_rt = 4'd7; id_rt_used = 1'b1;
    #1;
    chk("lu_rt_bubble", 32'(id_ex_bubble), 32'h1);
    tick();
    chk("lu_rt_stall", 32'(stall_cnt), 32'd2);
    id_rt_used = 1'b0;
    #1;
    chk("rt_unused_pc", 32'(pc_en), 32'h1);
    tick();
    chk("rt_unused_stall", 32'(stall_cnt), 32'd2);
    idle();

    // Mispredict alone.
    id_br_mispredict = 1'b1;
    #1;
    chk("br_flush", 32'(if_id_flush), 32'h1);
    chk("br_pc", 32'(pc_en), 32'h1);
    tick();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_state", 32'(state), 32'd0);

    // Mispredict masked by load-use, flushes one cycle later.
    ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1'b1;
    #1;
    chk("br_lu_flush", 32'(if_id_flush), 32'h0);
    chk("br_lu_bubble", 32'(id_ex_bubble), 32'h1);
    tick();
    chk("br_lu_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_lu_stall", 32'(stall_cnt), 32'd3);
    ex_mem_read = 1'b0;
    #1;
    chk("br_late_flush", 32'(if_id_flush), 32'h1);
    tick();
    chk("br_late_flush_cnt", 32'(flush_cnt), 32'd2);
    idle();

    // Three-cycle DMEM wait.
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dmem_ens", 32'(ens), 32'h0);
      chk("dmem_kill", 32'(wb_kill), 32'h1);
      tick();
    end
    chk("dmem_state", 32'(state), 32'd2);
    chk("dmem_stall", 32'(stall_cnt), 32'd6);
    chk("dmem_tmo", 32'(mem_timeout), 32'd0);
    dmem_ready = 1'b1;
    #1;
    chk("dmem_done_ens", 32'(ens), 32'h1f);
    tick();
    chk("dmem_done_state", 32'(state), 32'd0);
    idle();

    // Two-cycle IMEM miss.
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("imem_ens", 32'(ens), 32'b01111);
      chk("imem_flush", 32'(if_id_flush), 32'h1);
      tick();
    end
    chk("imem_state", 32'(state), 32'd3);
    chk("imem_stall", 32'(stall_cnt), 32'd8);
    chk("imem_flush_cnt", 32'(flush_cnt), 32'd2);
    idle();
    tick();
    chk("imem_done_state", 32'(state), 32'd0);

    // DMEM timeout: flag rises after the 16th waiting cycle and sticks.
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) chk("tmo_c15", 32'(mem_timeout), 32'd0);
      if (i == 16) chk("tmo_c16", 32'(mem_timeout), 32'd1);
    end
    idle();
    tick();
    chk("tmo_sticky", 32'(mem_timeout), 32'd1);
    chk("tmo_stall", 32'(stall_cnt), 32'd28);
    chk("tmo_state", 32'(state), 32'd0);

    // Halt: HLT retires, then everything freezes regardless of inputs.
    wb_halt = 1'b1;
    #1;
    chk("hlt_pc", 32'(pc_en), 32'h1);
    chk("hlt_kill", 32'(wb_kill), 32'h0);
    tick();
    wb_halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      {id_rs, id_rt, ex_rd} = 12'($urandom);
      {id_rs_used, id_rt_used, ex_mem_read, id_br_mispredict,
       imem_ready, mem_req, dmem_ready, wb_halt} = 8'($urandom);
      #1;
      chk("halt_flag", 32'(halted), 32'h1);
      chk("halt_ens", 32'(ens), 32'h0);
      chk("halt_state", 32'(state), 32'd4);
      tick();
    end
    chk("halt_stall_frozen", 32'(stall_cnt), 32'd28);
    chk("halt_flush_frozen", 32'(flush_cnt), 32'd2);

    // Reset out of HALTED.
    rst = 1'b1;
    #1;
    chk("halt_rst_ens", 32'(ens), 32'h1f);
    tick();
    idle();
    rst = 1'b0;
    #1;
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_stall", 32'(stall_cnt), 32'd0);
    chk("rst2_flush", 32'(flush_cnt), 32'd0);
    chk("rst2_tmo", 32'(mem_timeout), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
